// File: rtl/secuenciador_notas.sv
// secuenciador_notas: plays a small (nota, duracion) step table into ciclo_master.
// The host fills the table; on start the steps are played in order, with each step ending
// when the ciclo count fed back by ciclo_master wraps to zero.
module secuenciador_notas #(
  parameter int unsigned N_PASOS = 8,
  parameter int unsigned W_IDX   = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [W_IDX-1:0] wr_addr_i,
  input  logic [3:0]       wr_nota_i,
  input  logic [5:0]       wr_dur_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic [5:0]       ciclo_i,
  output logic             en_ciclo_o,
  output logic [5:0]       duracion_o,
  output logic [3:0]       nota_o,
  output logic [W_IDX-1:0] paso_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned W_NOTA = 4;
  localparam int unsigned W_DUR  = 6;

  typedef struct packed {
    logic [W_NOTA-1:0] nota;
    logic [W_DUR-1:0]  dur;
  } entrada_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CARGA,
    S_TOCA,
    S_PAUSA,
    S_FIN
  } state_e;

  entrada_t          tabla_q [N_PASOS];
  state_e            state_q;
  logic [W_IDX-1:0]  paso_q;
  logic [W_NOTA-1:0] nota_q;
  logic [W_DUR-1:0]  duracion_q;
  logic [W_DUR-1:0]  ciclo_prev_q;
  logic              en_ciclo_q;
  logic              busy_q;
  logic              done_q;

  entrada_t          entrada;
  logic [W_DUR-1:0]  duracion_d;
  logic [W_IDX-1:0]  paso_d;
  logic              fin_paso;
  logic              ultimo_paso;
  logic              fin_tabla;

  // Step table: host writes land on the edge in any state; reset clears every entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < N_PASOS; i++) begin
        tabla_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      tabla_q[wr_addr_i] <= '{nota: wr_nota_i, dur: wr_dur_i};
    end
  end

  // Entry under the current index and derived step-control conditions.
  always_comb begin
    entrada     = tabla_q[paso_q];
    fin_tabla   = (entrada.dur == '0);
    // A one-ciclo step would end immediately on the initial zero, so it is stretched to two.
    duracion_d  = (entrada.dur == W_DUR'(1)) ? W_DUR'(2) : entrada.dur;
    paso_d      = paso_q + W_IDX'(1);
    ultimo_paso = (paso_q == W_IDX'(N_PASOS - 1));
    // Step is over when the count has just wrapped from duracion-1 back to 0.
    fin_paso    = (ciclo_prev_q == (duracion_q - W_DUR'(1))) && (ciclo_i == '0);
  end

  // Playback FSM with registered outputs; stop overrides everything outside IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      paso_q       <= '0;
      nota_q       <= '0;
      duracion_q   <= '0;
      ciclo_prev_q <= '0;
      en_ciclo_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        en_ciclo_q <= 1'b0;
        busy_q     <= 1'b0;
        nota_q     <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              paso_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CARGA;
            end
          end
          S_CARGA: begin
            if (fin_tabla) begin
              if (loop_i) begin
                paso_q  <= '0;
                state_q <= S_CARGA;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end
            end else begin
              nota_q       <= entrada.nota;
              duracion_q   <= duracion_d;
              ciclo_prev_q <= '0;
              en_ciclo_q   <= 1'b1;
              state_q      <= S_TOCA;
            end
          end
          S_TOCA: begin
            ciclo_prev_q <= ciclo_i;
            if (fin_paso) begin
              en_ciclo_q <= 1'b0;
              state_q    <= S_PAUSA;
            end
          end
          S_PAUSA: begin
            if (ultimo_paso) begin
              if (loop_i) begin
                paso_q  <= '0;
                state_q <= S_CARGA;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end
            end else begin
              paso_q  <= paso_d;
              state_q <= S_CARGA;
            end
          end
          S_FIN: begin
            busy_q  <= 1'b0;
            nota_q  <= '0;
            state_q <= S_IDLE;
          end
          default: begin
            en_ciclo_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign en_ciclo_o = en_ciclo_q;
  assign duracion_o = duracion_q;
  assign nota_o     = nota_q;
  assign paso_o     = paso_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
